uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//   UART receiver stage feeding the UART/ALU interface: deserialises the rx line into
//   N_BITS_DATA-bit words (LSB first, 1 start, 1 stop) using an external oversampling
//   baud tick. Presents each completed word on dout with a one-cycle rx_done_ticks pulse.
//   Sits between the pad-level rx pin / baud-rate generator and the interface block.
// PARAMETERS
//   N_BITS_DATA  8   data bits per frame
//   OVERSAMPLE   16  s_tick pulses per bit period (even, >=4)
//   SB_TICKS     16  s_tick pulses spent in the stop bit (16 = 1 stop bit)
//   PARITY_ODD   0   parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd)
// PORTS
//   clock          in   1            system clock, rising edge
//   reset          in   1            asynchronous, active-low reset
//   s_tick         in   1            one-cycle baud tick at OVERSAMPLE x bit rate
//   rx             in   1            serial line, idle high, asynchronous to clock
//   dout           out  N_BITS_DATA  last received word
//   rx_done_ticks  out  1            one-cycle pulse: dout/frame_error/parity_error valid
//   frame_error    out  1            stop bit sampled low in the last frame
//   parity_error   out  1            parity mismatch in the last frame (0 if feature off)
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, counters 0, shift reg 0, sync FFs=1'b1,
//     dout=0, rx_done_ticks=0, frame_error=0, parity_error=0. Reset mid-frame discards
//     the partial word; no pulse is issued.
//   - rx passes through a 2-FF synchroniser (rx_s); all sampling uses rx_s.
//   - Tick counter cnt (log2(max(OVERSAMPLE,SB_TICKS)) bits) advances only on s_tick.
//   - FSM states IDLE, START, DATA, [PARITY], STOP:
//     IDLE : s_tick ignored; rx_s==0 -> START, cnt=0.
//     START: on s_tick at cnt==OVERSAMPLE/2-1: rx_s==0 -> DATA, cnt=0, bit_idx=0;
//            rx_s==1 -> glitch, back to IDLE, no pulse. Otherwise cnt++.
//     DATA : on s_tick at cnt==OVERSAMPLE-1: shreg={rx_s, shreg[N-1:1]}, cnt=0;
//            bit_idx==N_BITS_DATA-1 -> PARITY (feature on) or STOP; else bit_idx++.
//     PARITY: on s_tick at cnt==OVERSAMPLE-1: capture rx_s as par_bit, cnt=0 -> STOP.
//     STOP : on s_tick at cnt==SB_TICKS-1: -> IDLE; in the same clock edge register
//            dout=shreg, frame_error=~rx_s, parity_error=mismatch, rx_done_ticks=1.
//   - rx_done_ticks high exactly one clock, the clock after the final stop tick edge;
//     it is 0 in every other cycle. dout/frame_error/parity_error hold until next frame.
//   - Frames with frame_error still update dout and pulse rx_done_ticks.
//   - A new start bit is accepted in the cycle after STOP->IDLE (back-to-back frames).
//   - Sampling at mid-bit: start verified at OVERSAMPLE/2 ticks, data every OVERSAMPLE.
//   - rx held low permanently: after a frame_error frame, FSM re-enters START at once.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: PARITY state present, one parity bit after data;
//     parity_error = (^shreg ^ par_bit) != PARITY_ODD.
//   Undefined: no PARITY state, DATA -> STOP directly, parity_error tied 0.
// TESTING (OVERSAMPLE=16, SB_TICKS=16, s_tick every 4 clocks)
//   1 frame 0xA5 (LSB first, stop=1) -> one rx_done_ticks pulse, dout=0xA5, frame_error=0.
//   2 rx low for 6 ticks then high -> returns to IDLE, no pulse, dout unchanged.
//   3 frame 0x3C with stop bit=0 -> pulse, dout=0x3C, frame_error=1; next good 0x01 -> 0.
//   4 frames 0x00,0xFF back-to-back, no idle gap -> two pulses, dout 0x00 then 0xFF.
//   5 reset low during bit 4 of 0x55, then frame 0x12 -> no pulse for 0x55, dout=0x12.
//   6 UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with par=1 -> parity_error=0; par=0 -> 1.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// UART receiver: 1 start, N_BITS_DATA data bits (LSB first), 1 stop, driven by an oversampling baud tick.
// Define UART_RX_PARITY_EN to add one parity bit after the data (sense chosen by PARITY_ODD).
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | confirming start bit at mid-bit
//   DATA   | sampling data bits at mid-bit
//   PARITY | sampling parity bit (UART_RX_PARITY_EN only)
//   STOP   | waiting SB_TICKS, then publish word and flags
module uart_rx_oversample #(
  parameter int N_BITS_DATA = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SB_TICKS    = 16,
  parameter int PARITY_ODD  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_tick,
  input  logic                   rx,
  output logic [N_BITS_DATA-1:0] dout,
  output logic                   rx_done_ticks,
  output logic                   frame_error,
  output logic                   parity_error
);

  localparam int CNT_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (N_BITS_DATA > 1) ? $clog2(N_BITS_DATA) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [N_BITS_DATA-1:0] shreg;
  logic [1:0]             sync_q;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      dout          <= '0;
      rx_done_ticks <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
`endif
    end else begin
      rx_done_ticks <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (cnt == CW'(OVERSAMPLE/2 - 1)) begin
              // a high line at mid start bit was a glitch, not a frame
              if (!rx_s) begin
                state   <= DATA;
                cnt     <= '0;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (cnt == CW'(OVERSAMPLE - 1)) begin
              shreg <= {rx_s, shreg[N_BITS_DATA-1:1]};
              cnt   <= '0;
              if (bit_idx == BW'(N_BITS_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (cnt == CW'(OVERSAMPLE - 1)) begin
              par_bit <= rx_s;
              cnt     <= '0;
              state   <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (cnt == CW'(SB_TICKS - 1)) begin
              state         <= IDLE;
              dout          <= shreg;
              frame_error   <= ~rx_s;
              rx_done_ticks <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_error  <= (^shreg ^ par_bit) != (PARITY_ODD != 0);
`else
              parity_error  <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: 16x oversampling, s_tick every 4 clocks (64 clocks per bit).
// Builds with or without UART_RX_PARITY_EN; frames carry a parity bit when it is defined.
module tb_uart_rx_oversample;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_ticks;
  logic       frame_error;
  logic       parity_error;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int long_pulses = 0;
  int exp_pulses = 0;
  int tdiv = 0;
  logic prev_done = 1'b0;
  logic [7:0] hist[$];

  uart_rx_oversample #(
    .N_BITS_DATA(8),
    .OVERSAMPLE(16),
    .SB_TICKS(16),
    .PARITY_ODD(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_tick(s_tick),
    .rx(rx),
    .dout(dout),
    .rx_done_ticks(rx_done_ticks),
    .frame_error(frame_error),
    .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    tdiv = (tdiv + 1) % 4;
    s_tick = (tdiv == 0);
  end

  always @(negedge clock) begin
    if (rx_done_ticks === 1'b1) begin
      pulses++;
      hist.push_back(dout);
      if (prev_done === 1'b1) long_pulses++;
    end
    prev_done = rx_done_ticks;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            input int stop_clks);
    rx = 1'b0;
    bit_time(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_time(64);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d ^ par_flip;
    bit_time(64);
`endif
    rx = stop_bit;
    bit_time(stop_clks);
    rx = 1'b1;
  endtask

  initial begin
    bit_time(5);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_done", 32'(rx_done_ticks), 32'h0);
    chk("reset_ferr", 32'(frame_error), 32'h0);
    chk("reset_perr", 32'(parity_error), 32'h0);
    reset = 1'b1;
    bit_time(64);

    // single good frame
    send_frame(8'hA5, 1'b1, 1'b0, 64);
    bit_time(64);
    exp_pulses = 1;
    chk("a5_pulses", 32'(pulses), 32'(exp_pulses));
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_ferr", 32'(frame_error), 32'h0);
    chk("a5_perr", 32'(parity_error), 32'h0);

    // start glitch of 6 ticks
    rx = 1'b0;
    bit_time(24);
    rx = 1'b1;
    bit_time(192);
    chk("glitch_pulses", 32'(pulses), 32'(exp_pulses));
    chk("glitch_dout", 32'(dout), 32'hA5);

    // bad stop bit, then a good frame clears the flag
    send_frame(8'h3C, 1'b0, 1'b0, 48);
    bit_time(128);
    exp_pulses = 2;
    chk("3c_pulses", 32'(pulses), 32'(exp_pulses));
    chk("3c_dout", 32'(dout), 32'h3C);
    chk("3c_ferr", 32'(frame_error), 32'h1);
    send_frame(8'h01, 1'b1, 1'b0, 64);
    bit_time(64);
    exp_pulses = 3;
    chk("01_pulses", 32'(pulses), 32'(exp_pulses));
    chk("01_dout", 32'(dout), 32'h01);
    chk("01_ferr", 32'(frame_error), 32'h0);

    // back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 64);
    send_frame(8'hFF, 1'b1, 1'b0, 64);
    bit_time(64);
    exp_pulses = 5;
    chk("b2b_pulses", 32'(pulses), 32'(exp_pulses));
    chk("b2b_first", 32'(hist[3]), 32'h00);
    chk("b2b_second", 32'(hist[4]), 32'hFF);
    chk("b2b_ferr", 32'(frame_error), 32'h0);

    // reset in the middle of bit 4 of 0x55
    rx = 1'b0;
    bit_time(64);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      bit_time(64);
    end
    rx = 1'b1;
    bit_time(20);
    reset = 1'b0;
    bit_time(4);
    chk("midrst_dout", 32'(dout), 32'h00);
    chk("midrst_done", 32'(rx_done_ticks), 32'h0);
    reset = 1'b1;
    bit_time(640);
    chk("midrst_pulses", 32'(pulses), 32'(exp_pulses));
    send_frame(8'h12, 1'b1, 1'b0, 64);
    bit_time(64);
    exp_pulses = 6;
    chk("12_pulses", 32'(pulses), 32'(exp_pulses));
    chk("12_dout", 32'(dout), 32'h12);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 64);
    bit_time(64);
    exp_pulses = 7;
    chk("par_ok_pulses", 32'(pulses), 32'(exp_pulses));
    chk("par_ok_perr", 32'(parity_error), 32'h0);
    send_frame(8'h07, 1'b1, 1'b1, 64);
    bit_time(64);
    exp_pulses = 8;
    chk("par_bad_pulses", 32'(pulses), 32'(exp_pulses));
    chk("par_bad_dout", 32'(dout), 32'h07);
    chk("par_bad_perr", 32'(parity_error), 32'h1);
`else
    chk("nopar_perr", 32'(parity_error), 32'h0);
`endif

    chk("pulse_width", 32'(long_pulses), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
